branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline, replacing the decode-stage "compare and redirect" scheme with a fetch-stage prediction. It holds a pattern history table (PHT) of saturating counters, indexed bimodally or gshare-style, and a direct-mapped branch target buffer (BTB). It predicts direction and target for the fetch PC in the same cycle. It trains from the resolve stage and keeps branch and mispredict performance counters.

## Interface
- `ENTRIES`, 64: PHT and BTB entry count; a power of 2, from 4 to 1024. `IDX_W = log2(ENTRIES)`.
- `CNT_W`, 2: PHT counter width, from 1 to 4.
- `USE_GSHARE`, 1: 1 gives index = pc bits XOR GHR; 0 gives bimodal index = pc bits.
- `GHR_W`, 8: global history length, from 1 to IDX_W. It is ignored when USE_GSHARE=0.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `lookup_pc` in 32: fetch-stage PC.
- `pred_take` out 1: predicted taken.
- `pred_target` out 32: predicted target; meaningful only when pred_take=1.
- `pred_idx` out IDX_W: index used; the pipeline carries it to resolve.
- `upd_valid` in 1: a conditional branch resolved this cycle.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_idx` in IDX_W: pred_idx captured at that branch's lookup.
- `upd_taken` in 1: actual direction.
- `upd_target` in 32: actual taken target.
- `upd_pred_take` in 1: prediction made at lookup.
- `upd_pred_target` in 32: target predicted at lookup.
- `upd_mispredict` out 1: combinational; high when upd_valid and the prediction was wrong.
- `perf_branches` out 32: count of upd_valid cycles; saturating.
- `perf_mispredicts` out 32: count of upd_mispredict cycles; saturating.

## Operation
- Field split:
  - pc bits [IDX_W+1:2] are the PC index.
  - pc bits [31:IDX_W+2] are the tag, `TAG_W = 30-IDX_W`.
- Lookup index:
  - USE_GSHARE=0: PC index.
  - USE_GSHARE=1: PC index XOR the GHR, zero-extended to IDX_W.
- BTB hit: the entry at `lookup_pc`'s PC index (never the XORed index) has valid=1 and a tag equal to lookup_pc's tag.
- `pred_take` = PHT[pred_idx] MSB AND BTB hit. With no stored target the prediction is not-taken.
- `pred_target` = BTB target on a hit; lookup_pc+4 otherwise.
- `upd_mispredict` = upd_valid AND (upd_taken ≠ upd_pred_take OR (upd_taken AND upd_target ≠ upd_pred_target)).
- On upd_valid, at the rising edge:
  - PHT[upd_idx] increments if taken and decrements if not, saturating at 0 and 2^CNT_W−1.
  - If upd_taken, the BTB entry at upd_pc's PC index is written with valid=1, tag, and upd_target. A not-taken branch leaves the BTB unchanged.
  - GHR ← {GHR[GHR_W-2:0], upd_taken}. The GHR is non-speculative and shifts only at resolve.
  - perf_branches increments. perf_mispredicts increments if upd_mispredict. Both hold at 0xFFFF_FFFF.
- The update path uses upd_idx, not a recomputed index, so PHT training always targets the entry that produced the prediction.

## Timing
- Lookup is combinational from lookup_pc and current state, with zero latency.
- An update becomes visible to lookup on the cycle after the edge that writes it.
- A same-cycle lookup and update to the same entry: the lookup returns the pre-update value; there is no bypass.
- Reset values, while rst=0:
  - every PHT counter = 2^(CNT_W-1)−1 (weakly not-taken; 01 for CNT_W=2);
  - every BTB valid = 0; BTB tags and targets = 0;
  - GHR = 0; both perf counters = 0.
- Outputs after reset: pred_take=0, pred_target=lookup_pc+4, pred_idx per the index rule with GHR=0.
- Reset asserted mid-operation clears all state immediately and asynchronously. upd_valid is ignored while rst=0.
- With rst=1 and upd_valid=0, all state holds.

## Structure
- Package `bp_pkg` holds:
  - function `clog2`;
  - a counter-init constant function of CNT_W;
  - the field-split helpers (index, tag).
- Sub-module `sat_counter`, parameterised by CNT_W, provides the next-value logic: inc/dec with saturation. It is instantiated once on the update path.
- State is PHT, BTB (valid, tag, target), and GHR, all in flops so the async reset is possible. No RAM macros.

## Test plan
- **Reset:** ENTRIES=64, CNT_W=2. Hold rst=0, then release. Lookup 0xBFC0_0000 → pred_take=0, pred_target=0xBFC0_0004; both perf counters 0.
- **Bimodal training:** USE_GSHARE=0, branch at pc 0x0000_0040 to 0x0000_0100.
  - Update taken once → counter 10, BTB written; next-cycle lookup gives pred_take=1, pred_target=0x100.
  - Two more taken updates → counter saturates at 11.
  - One not-taken update → counter 10, pred_take still 1.
- **Tag alias:** after the previous case, lookup 0x0000_0140 (same index, different tag) → BTB miss, pred_take=0.
- **Gshare:** GHR_W=4, four taken updates so GHR=1111. Lookup pc 0x0000_0000 → pred_idx=0x0F; an update with upd_idx=0x0F trains only entry 15.
- **Mispredict and counters:**
  - upd_taken=1, upd_pred_take=1, upd_target=0x200, upd_pred_target=0x204 → upd_mispredict=1; perf_mispredicts increments.
  - Force perf_branches to 0xFFFF_FFFF, then apply an update → it stays 0xFFFF_FFFF.
- **Collision and mid-run reset:** a same-cycle lookup and update on entry 5 returns the old counter; the next cycle shows the new one. Pulse rst low mid-run → all predictions immediately revert to the reset values.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: integer log2, PHT counter reset value,
// and the PC field split into PHT/BTB index and BTB tag.
package bp_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // Weakly not-taken: the value just below the counter midpoint.
    function automatic int cnt_init(input int cnt_w);
        return (32'sd1 << (cnt_w - 32'sd1)) - 32'sd1;
    endfunction

    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
        return pc >> (idx_w + 32'sd2);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for one saturating up/down counter of CNT_W bits.
module sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_value
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};

    // Step toward the requested direction unless already pinned at that end.
    always_comb begin
        o_value = i_value;
        if (i_inc) begin
            if (i_value != CNT_MAX) begin
                o_value = i_value + CNT_W'(1'b1);
            end else begin
                o_value = i_value;
            end
        end else begin
            if (i_value != CNT_MIN) begin
                o_value = i_value - CNT_W'(1'b1);
            end else begin
                o_value = i_value;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: PHT of saturating counters (bimodal or gshare index)
// plus a direct-mapped BTB, trained from resolve, with saturating perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES    = 64,
    parameter int CNT_W      = 2,
    parameter int USE_GSHARE = 1,
    parameter int GHR_W      = 8,
    localparam int IDX_W     = clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      lookup_pc,
    output logic             pred_take,
    output logic [31:0]      pred_target,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_take,
    input  logic [31:0]      upd_pred_target,
    output logic             upd_mispredict,
    output logic [31:0]      perf_branches,
    output logic [31:0]      perf_mispredicts
);

    localparam int               TAG_W     = 30 - IDX_W;
    localparam logic [31:0]      PERF_MAX  = 32'hFFFF_FFFF;
    localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(cnt_init(CNT_W));

    logic [CNT_W-1:0]   r_pht [ENTRIES];
    logic [ENTRIES-1:0] r_btb_valid;
    logic [TAG_W-1:0]   r_btb_tag [ENTRIES];
    logic [31:0]        r_btb_target [ENTRIES];
    logic [GHR_W-1:0]   r_ghr;
    logic [31:0]        r_perf_branches;
    logic [31:0]        r_perf_mispredicts;

    logic [IDX_W-1:0]   w_pc_idx;
    logic [IDX_W-1:0]   w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [IDX_W-1:0]   w_upd_pc_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_btb_hit;
    logic               w_mispredict;
    logic [CNT_W-1:0]   w_pht_next;

    assign w_pc_idx     = IDX_W'(pc_index(lookup_pc, IDX_W));
    assign w_lk_tag     = TAG_W'(pc_tag(lookup_pc, IDX_W));
    assign w_upd_pc_idx = IDX_W'(pc_index(upd_pc, IDX_W));
    assign w_upd_tag    = TAG_W'(pc_tag(upd_pc, IDX_W));

    // Lookup: the BTB is always addressed by the raw PC index, only the PHT sees history.
    always_comb begin
        if (USE_GSHARE != 0) begin
            w_lk_idx = w_pc_idx ^ IDX_W'(r_ghr);
        end else begin
            w_lk_idx = w_pc_idx;
        end
        w_btb_hit = r_btb_valid[w_pc_idx] && (r_btb_tag[w_pc_idx] == w_lk_tag);
        pred_take = r_pht[w_lk_idx][CNT_W-1] && w_btb_hit;
        if (w_btb_hit) begin
            pred_target = r_btb_target[w_pc_idx];
        end else begin
            pred_target = lookup_pc + 32'd4;
        end
    end

    assign pred_idx       = w_lk_idx;
    assign w_mispredict   = upd_valid && ((upd_taken != upd_pred_take) ||
                                          (upd_taken && (upd_target != upd_pred_target)));
    assign upd_mispredict = w_mispredict;

    sat_counter #(.CNT_W(CNT_W)) u_pht_ctr (
        .i_value (r_pht[upd_idx]),
        .i_inc   (upd_taken),
        .o_value (w_pht_next)
    );

    // PHT training at the index the prediction came from, not a recomputed one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= CNT_RESET;
            end
        end else if (upd_valid) begin
            r_pht[upd_idx] <= w_pht_next;
        end
    end

    // BTB fill on taken branches only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btb_valid <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb_tag[i]    <= {TAG_W{1'b0}};
                r_btb_target[i] <= 32'd0;
            end
        end else if (upd_valid && upd_taken) begin
            r_btb_valid[w_upd_pc_idx]  <= 1'b1;
            r_btb_tag[w_upd_pc_idx]    <= w_upd_tag;
            r_btb_target[w_upd_pc_idx] <= upd_target;
        end
    end

    // Non-speculative global history and saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr              <= {GHR_W{1'b0}};
            r_perf_branches    <= 32'd0;
            r_perf_mispredicts <= 32'd0;
        end else if (upd_valid) begin
            r_ghr <= GHR_W'({r_ghr, upd_taken});
            if (r_perf_branches != PERF_MAX) begin
                r_perf_branches <= r_perf_branches + 32'd1;
            end
            if (w_mispredict && (r_perf_mispredicts != PERF_MAX)) begin
                r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
            end
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare (GHR_W=4) instance share stimulus
// and are compared against an array-based model of the predictor's rules.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_take;
    logic [31:0] upd_pred_target;

    logic        p_take [2];
    logic [31:0] p_tgt  [2];
    logic [5:0]  p_idx  [2];
    logic        p_mis  [2];
    logic [31:0] p_pb   [2];
    logic [31:0] p_pm   [2];

    int total = 0;
    int bad   = 0;

    int          m_pht [64];
    bit          m_bv  [64];
    logic [23:0] m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ghr;
    logic [31:0] m_pb, m_pm;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(64), .CNT_W(2), .USE_GSHARE(0), .GHR_W(8)) dut_bi (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_take(p_take[0]), .pred_target(p_tgt[0]), .pred_idx(p_idx[0]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_take(upd_pred_take), .upd_pred_target(upd_pred_target),
        .upd_mispredict(p_mis[0]), .perf_branches(p_pb[0]), .perf_mispredicts(p_pm[0])
    );

    branch_predictor #(.ENTRIES(64), .CNT_W(2), .USE_GSHARE(1), .GHR_W(4)) dut_gs (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_take(p_take[1]), .pred_target(p_tgt[1]), .pred_idx(p_idx[1]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_take(upd_pred_take), .upd_pred_target(upd_pred_target),
        .upd_mispredict(p_mis[1]), .perf_branches(p_pb[1]), .perf_mispredicts(p_pm[1])
    );

    function automatic int pcidx(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd64);
    endfunction

    function automatic logic [23:0] pctag(input logic [31:0] pc);
        return 24'(pc / 32'd256);
    endfunction

    function automatic int m_index(input int k, input logic [31:0] pc);
        return (k == 0) ? pcidx(pc) : (pcidx(pc) ^ m_ghr);
    endfunction

    // Expected {pred_take, pred_target, pred_idx} for instance k.
    function automatic logic [38:0] m_pred(input int k, input logic [31:0] pc);
        int  i;
        bit  hit;
        bit  take;
        i    = pcidx(pc);
        hit  = m_bv[i] && (m_tag[i] == pctag(pc));
        take = hit && (m_pht[m_index(k, pc)] >= 2);
        return {take, (hit ? m_tgt[i] : pc + 32'd4), 6'(m_index(k, pc))};
    endfunction

    function automatic bit m_mis();
        return upd_valid && ((upd_taken != upd_pred_take) ||
                             (upd_taken && (upd_target != upd_pred_target)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_pht[i] = 1;
            m_bv[i]  = 1'b0;
            m_tag[i] = 24'd0;
            m_tgt[i] = 32'd0;
        end
        m_ghr = 0;
        m_pb  = 32'd0;
        m_pm  = 32'd0;
    endtask

    task automatic model_update();
        int j;
        if (upd_taken) m_pht[upd_idx] = (m_pht[upd_idx] < 3) ? m_pht[upd_idx] + 1 : 3;
        else           m_pht[upd_idx] = (m_pht[upd_idx] > 0) ? m_pht[upd_idx] - 1 : 0;
        if (upd_taken) begin
            j        = pcidx(upd_pc);
            m_bv[j]  = 1'b1;
            m_tag[j] = pctag(upd_pc);
            m_tgt[j] = upd_target;
        end
        m_ghr = (m_ghr * 2 + int'(upd_taken)) % 16;
        if (m_mis() && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 32'd1;
        if (m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 32'd1;
    endtask

    task automatic drive(input logic [31:0] lpc, input logic v, input logic [31:0] pc,
                         input logic [5:0] idx, input logic t, input logic [31:0] tg,
                         input logic pt, input logic [31:0] ptg);
        lookup_pc = lpc; upd_valid = v; upd_pc = pc; upd_idx = idx; upd_taken = t;
        upd_target = tg; upd_pred_take = pt; upd_pred_target = ptg;
        #1;
    endtask

    task automatic tick();
        if (upd_valid && rst) model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        drive(32'hBFC0_0000, 1'b1, 32'h40, 6'd16, 1'b1, 32'h100, 1'b0, 32'h0);
        tick(); tick();
        rst = 1'b1;
        drive(32'hBFC0_0000, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({p_take[k], p_tgt[k], p_idx[k]} !== {1'b0, 32'hBFC0_0004, 6'd0}) begin
                bad++;
                $display("FAIL reset_pred[%0d]: got %h want %h", k, {p_take[k], p_tgt[k], p_idx[k]}, {1'b0, 32'hBFC0_0004, 6'd0});
            end
            total++;
            if ({p_pb[k], p_pm[k]} !== 64'd0) begin
                bad++;
                $display("FAIL reset_perf[%0d]: got %h/%h want 0/0", k, p_pb[k], p_pm[k]);
            end
        end
    endtask

    task automatic test_bimodal();
        logic want [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic taken [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        drive(32'h40, 1'b1, 32'h40, 6'd16, 1'b1, 32'h100, 1'b0, 32'h44);
        total++;
        if (p_take[0] !== 1'b0) begin
            bad++;
            $display("FAIL bimodal_untrained: got %b want 0", p_take[0]);
        end
        for (int n = 0; n < 4; n++) begin
            if (n > 0) drive(32'h40, 1'b1, 32'h40, 6'd16, taken[n], 32'h100, 1'b1, 32'h100);
            tick();
            drive(32'h40, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
            total++;
            if ({p_take[0], p_tgt[0]} !== {want[n], 32'h100}) begin
                bad++;
                $display("FAIL bimodal_step%0d: got %b/%h want %b/%h", n, p_take[0], p_tgt[0], want[n], 32'h100);
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({p_take[k], p_tgt[k], p_idx[k]} !== m_pred(k, lookup_pc)) begin
                    bad++;
                    $display("FAIL bimodal_model[%0d] step%0d: got %h want %h", k, n, {p_take[k], p_tgt[k], p_idx[k]}, m_pred(k, lookup_pc));
                end
            end
        end
    endtask

    task automatic test_alias();
        drive(32'h140, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        total++;
        if ({p_take[0], p_tgt[0], p_idx[0]} !== {1'b0, 32'h144, 6'd16}) begin
            bad++;
            $display("FAIL tag_alias: got %h want %h", {p_take[0], p_tgt[0], p_idx[0]}, {1'b0, 32'h144, 6'd16});
        end
    endtask

    task automatic test_gshare();
        for (int n = 0; n < 4; n++) begin
            drive(32'h0, 1'b1, 32'h80, 6'd32, 1'b1, 32'h300, 1'b0, 32'h0);
            tick();
        end
        drive(32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        total++;
        if (p_idx[1] !== 6'h0F) begin
            bad++;
            $display("FAIL gshare_idx: got %h want 0f", p_idx[1]);
        end
        drive(32'h0, 1'b1, 32'h0, 6'h0F, 1'b1, 32'h500, 1'b0, 32'h4);
        tick();
        drive(32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        total++;
        if ({p_take[1], p_tgt[1], p_take[0]} !== {1'b1, 32'h500, 1'b0}) begin
            bad++;
            $display("FAIL gshare_train: got gs %b/%h bi %b want 1/500 0", p_take[1], p_tgt[1], p_take[0]);
        end
        total++;
        if (m_pht[0] !== 1 || {p_take[1], p_tgt[1], p_idx[1]} !== m_pred(1, lookup_pc)) begin
            bad++;
            $display("FAIL gshare_model: got %h want %h", {p_take[1], p_tgt[1], p_idx[1]}, m_pred(1, lookup_pc));
        end
    endtask

    task automatic test_mispredict();
        logic [31:0] pm_before;
        pm_before = m_pm;
        drive(32'h0, 1'b1, 32'h200, 6'd0, 1'b1, 32'h200, 1'b1, 32'h204);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (p_mis[k] !== 1'b1) begin
                bad++;
                $display("FAIL mispredict_target[%0d]: got %b want 1", k, p_mis[k]);
            end
        end
        tick();
        drive(32'h0, 1'b1, 32'h200, 6'd0, 1'b0, 32'h200, 1'b0, 32'h999);
        total++;
        if ({p_mis[0], p_pm[0], p_pm[1]} !== {1'b0, pm_before + 32'd1, pm_before + 32'd1}) begin
            bad++;
            $display("FAIL mispredict_count: got %b/%h/%h want 0/%h", p_mis[0], p_pm[0], p_pm[1], pm_before + 32'd1);
        end
        tick();
        drive(32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_perf_sat();
        force dut_bi.r_perf_branches = 32'hFFFF_FFFF;
        force dut_gs.r_perf_branches = 32'hFFFF_FFFF;
        #1;
        release dut_bi.r_perf_branches;
        release dut_gs.r_perf_branches;
        m_pb = 32'hFFFF_FFFF;
        drive(32'h0, 1'b1, 32'h200, 6'd0, 1'b0, 32'h0, 1'b1, 32'h200);
        tick();
        drive(32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({p_pb[k], p_pm[k]} !== {32'hFFFF_FFFF, m_pm}) begin
                bad++;
                $display("FAIL perf_saturate[%0d]: got %h/%h want ffffffff/%h", k, p_pb[k], p_pm[k], m_pm);
            end
        end
    endtask

    task automatic test_collision();
        drive(32'h0, 1'b1, 32'h14, 6'd5, 1'b1, 32'h600, 1'b0, 32'h0);
        tick();
        drive(32'h14, 1'b1, 32'h14, 6'd5, 1'b0, 32'h0, 1'b1, 32'h600);
        total++;
        if ({p_take[0], p_tgt[0]} !== {1'b1, 32'h600}) begin
            bad++;
            $display("FAIL collision_old: got %b/%h want 1/600", p_take[0], p_tgt[0]);
        end
        tick();
        drive(32'h14, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        total++;
        if ({p_take[0], p_tgt[0]} !== {1'b0, 32'h600}) begin
            bad++;
            $display("FAIL collision_new: got %b/%h want 0/600", p_take[0], p_tgt[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] lpc, upc, tg, ptg;
        logic [5:0]  idx;
        logic        v, t, pt;
        logic [38:0] guess;
        for (int n = 0; n < 400; n++) begin
            lpc   = 32'($urandom_range(0, 1023)) << 2;
            upc   = 32'($urandom_range(0, 1023)) << 2;
            v     = 1'($urandom_range(0, 1));
            t     = 1'($urandom_range(0, 1));
            tg    = 32'($urandom()) & 32'hFFFF_FFFC;
            idx   = ($urandom_range(0, 1) == 0) ? 6'(m_index(1, upc)) : 6'($urandom_range(0, 63));
            guess = m_pred(0, upc);
            if ($urandom_range(0, 2) != 0) begin
                pt  = guess[38];
                ptg = guess[37:6];
                if ($urandom_range(0, 3) == 0) tg = ptg;
            end else begin
                pt  = 1'($urandom_range(0, 1));
                ptg = 32'($urandom()) & 32'hFFFF_FFFC;
            end
            drive(lpc, v, upc, idx, t, tg, pt, ptg);
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({p_take[k], p_tgt[k], p_idx[k], p_mis[k]} !== {m_pred(k, lpc), m_mis()}) begin
                    bad++;
                    $display("FAIL random_pred[%0d] n=%0d pc=%h: got %h want %h", k, n, lpc, {p_take[k], p_tgt[k], p_idx[k], p_mis[k]}, {m_pred(k, lpc), m_mis()});
                end
                total++;
                if ({p_pb[k], p_pm[k]} !== {m_pb, m_pm}) begin
                    bad++;
                    $display("FAIL random_perf[%0d] n=%0d: got %h/%h want %h/%h", k, n, p_pb[k], p_pm[k], m_pb, m_pm);
                end
            end
            tick();
        end
    endtask

    task automatic test_midrun_reset();
        drive(32'h14, 1'b1, 32'h14, 6'd5, 1'b1, 32'h700, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({p_take[k], p_tgt[k], p_idx[k], p_pb[k], p_pm[k]} !== {1'b0, 32'h18, 6'd5, 64'd0}) begin
                bad++;
                $display("FAIL midrun_reset[%0d]: got %h want %h", k, {p_take[k], p_tgt[k], p_idx[k], p_pb[k], p_pm[k]}, {1'b0, 32'h18, 6'd5, 64'd0});
            end
        end
        tick();
        rst = 1'b1;
        drive(32'h14, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({p_take[k], p_tgt[k], p_idx[k]} !== m_pred(k, lookup_pc)) begin
                bad++;
                $display("FAIL after_reset[%0d]: got %h want %h", k, {p_take[k], p_tgt[k], p_idx[k]}, m_pred(k, lookup_pc));
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b0;
        drive(32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        test_reset();
        test_bimodal();
        test_alias();
        test_gshare();
        test_mispredict();
        test_perf_sat();
        test_collision();
        test_random();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
